ws2812b_multi_driver: RTL and testbench

//  Multi-channel WS2812B LED-strip peripheral on the TinyQV byte bus. CPU queues pixel commands
//  {colour, repeat count, channel, latch} into a FIFO. An internal bit engine serialises them,
//  MSB-first G,R,B, onto one of NUM_CH strip outputs, with global brightness scaling.

---
 rtl/ws2812_pkg.sv | 53 +++++
 rtl/ws2812_bit_engine.sv | 148 ++++++++++++++
 rtl/ws2812b_multi_driver.sv | 146 ++++++++++++++
 tb/tb_ws2812b_multi_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared constants for the WS2812B multi-channel strip driver.
//   - register address map and STATUS bit positions
//   - default bit/latch timing in clock cycles (64 MHz)
//   - FIFO entry layout: {ch, latch, repeat[6:0], G, R, B}
//   - engine state encoding and the brightness scaling helper
package ws2812_pkg;

  localparam logic [3:0] ADDR_CMD     = 4'h0;
  localparam logic [3:0] ADDR_G       = 4'h1;
  localparam logic [3:0] ADDR_R       = 4'h2;
  localparam logic [3:0] ADDR_B       = 4'h3;
  localparam logic [3:0] ADDR_CHSEL   = 4'h4;
  localparam logic [3:0] ADDR_BRIGHT  = 4'h5;
  localparam logic [3:0] ADDR_CLR_OVF = 4'h7;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_FULL      = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_LEVEL_LSB = 4;

  localparam int unsigned DEF_T0H_CYC  = 26;
  localparam int unsigned DEF_T1H_CYC  = 51;
  localparam int unsigned DEF_TBIT_CYC = 80;
  localparam int unsigned DEF_TRST_CYC = 19200;

  localparam int unsigned ENT_B_LSB     = 0;
  localparam int unsigned ENT_R_LSB     = 8;
  localparam int unsigned ENT_G_LSB     = 16;
  localparam int unsigned ENT_REP_LSB   = 24;
  localparam int unsigned ENT_REP_W     = 7;
  localparam int unsigned ENT_LATCH_BIT = 31;
  localparam int unsigned ENT_CH_LSB    = 32;

  function automatic int unsigned entry_width(input int unsigned ch_w);
    return ENT_CH_LSB + ch_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BITS  = 2'd2,
    ST_LATCH = 2'd3
  } eng_state_e;

  // (c * (bright + 1)) >> 8; bright = 0xFF leaves c unchanged.
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] bright);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, bright} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws2812_bit_engine.sv
// ws2812_bit_engine: pops command entries and serialises them onto one strip line.
//   clk, rst_n       clock, synchronous active-low reset
//   entry_valid_i    FIFO holds at least one entry
//   entry_i          head FIFO entry
//   bright_i         global brightness, sampled when an entry is popped
//   entry_ready_o    pop strobe (asserted only while entry_valid_i)
//   led_o            registered strip lines, only the entry's channel toggles
//   active_o         engine not idle
module ws2812_bit_engine
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
  parameter int unsigned TBIT_CYC = DEF_TBIT_CYC,
  parameter int unsigned TRST_CYC = DEF_TRST_CYC,
  localparam int unsigned CH_W    = $clog2(NUM_CH),
  localparam int unsigned ENT_W   = entry_width(CH_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entry_valid_i,
  input  logic [ENT_W-1:0]  entry_i,
  input  logic [7:0]        bright_i,
  output logic              entry_ready_o,
  output logic [NUM_CH-1:0] led_o,
  output logic              active_o
);

  localparam int unsigned CNT_MAX = (TRST_CYC > TBIT_CYC) ? TRST_CYC : TBIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  eng_state_e           state_q, state_d;
  logic [23:0]          shift_q, shift_d;
  logic [23:0]          col_q, col_d;
  logic [4:0]           bit_q, bit_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  logic [ENT_REP_W-1:0] rep_q, rep_d;
  logic                 latch_q, latch_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [NUM_CH-1:0]    led_q, led_d;
  logic [23:0]          scaled;
  logic [CNT_W-1:0]     thigh;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    col_d         = col_q;
    bit_d         = bit_q;
    cyc_d         = cyc_q;
    rep_d         = rep_q;
    latch_d       = latch_q;
    ch_d          = ch_q;
    entry_ready_o = 1'b0;
    scaled        = '0;
    led_d         = '0;
    thigh         = '0;

    case (state_q)
      ST_IDLE: begin
        if (entry_valid_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (entry_valid_i) begin
          entry_ready_o = 1'b1;
          scaled  = {scale_byte(entry_i[ENT_G_LSB +: 8], bright_i),
                     scale_byte(entry_i[ENT_R_LSB +: 8], bright_i),
                     scale_byte(entry_i[ENT_B_LSB +: 8], bright_i)};
          col_d   = scaled;
          shift_d = scaled;
          bit_d   = '0;
          cyc_d   = '0;
          rep_d   = entry_i[ENT_REP_LSB +: ENT_REP_W];
          latch_d = entry_i[ENT_LATCH_BIT];
          ch_d    = entry_i[ENT_CH_LSB +: CH_W];
          state_d = ST_BITS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BITS: begin
        if (cyc_q == CNT_W'(TBIT_CYC - 1)) begin
          cyc_d = '0;
          if (bit_q == 5'd23) begin
            // Repeats reload the saved scaled colour so pixels stay back-to-back.
            if (rep_q != '0) begin
              rep_d   = rep_q - 1'b1;
              shift_d = col_q;
              bit_d   = '0;
            end else if (latch_q) begin
              state_d = ST_LATCH;
            end else begin
              state_d = entry_valid_i ? ST_LOAD : ST_IDLE;
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (cyc_q == CNT_W'(TRST_CYC - 1)) begin
          cyc_d   = '0;
          state_d = entry_valid_i ? ST_LOAD : ST_IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is decoded from next-state so led_o comes straight from a flop.
    thigh = shift_d[23] ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      led_d[i] = (state_d == ST_BITS) && (cyc_d < thigh) && (ch_d == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      col_q   <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      rep_q   <= '0;
      latch_q <= 1'b0;
      ch_q    <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      col_q   <= col_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      rep_q   <= rep_d;
      latch_q <= latch_d;
      ch_q    <= ch_d;
      led_q   <= led_d;
    end
  end

  assign led_o    = led_q;
  assign active_o = (state_q != ST_IDLE);

endmodule

// File: rtl/ws2812b_multi_driver.sv
// ws2812b_multi_driver: WS2812B multi-strip peripheral on the TinyQV byte bus.
//   clk, rst_n     clock, synchronous active-low reset
//   address        register address
//   data_write     one-cycle write strobe
//   data_in        write data
//   data_out       read data, combinational on address
//   led            strip data lines, idle low
//   busy           engine active or command FIFO non-empty
module ws2812b_multi_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned T0H_CYC    = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC    = DEF_T1H_CYC,
  parameter int unsigned TBIT_CYC   = DEF_TBIT_CYC,
  parameter int unsigned TRST_CYC   = DEF_TRST_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        address,
  input  logic              data_write,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [NUM_CH-1:0] led,
  output logic              busy
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned ENT_W = entry_width(CH_W);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [7:0]       g_q, g_d, r_q, r_d, b_q, b_d, bright_q, bright_d;
  logic [CH_W-1:0]  chsel_q, chsel_d;
  logic             overflow_q, overflow_d;

  logic [ENT_W-1:0] fifo_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;

  logic             push, pop, accept, empty, full, eng_active;
  logic [ENT_W-1:0] new_entry;
  logic [7:0]       status;

  assign empty     = (count_q == '0);
  assign full      = (count_q == LVL_W'(FIFO_DEPTH));
  assign push      = data_write && (address == ADDR_CMD);
  // A push into a full FIFO still lands if the engine pops the same cycle.
  assign accept    = push && (!full || pop);
  assign new_entry = {chsel_q, data_in[7], data_in[6:0], g_q, r_q, b_q};
  assign busy      = eng_active || !empty;

  always_comb begin
    g_d        = g_q;
    r_d        = r_q;
    b_d        = b_q;
    chsel_d    = chsel_q;
    bright_d   = bright_q;
    overflow_d = overflow_q;
    if (data_write) begin
      case (address)
        ADDR_G:       g_d        = data_in;
        ADDR_R:       r_d        = data_in;
        ADDR_B:       b_d        = data_in;
        ADDR_CHSEL:   chsel_d    = data_in[CH_W-1:0];
        ADDR_BRIGHT:  bright_d   = data_in;
        ADDR_CLR_OVF: overflow_d = 1'b0;
        default: ;
      endcase
    end
    // A new overflow wins over a same-cycle clear.
    if (push && full && !pop) overflow_d = 1'b1;

    wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (accept && !pop)      count_d = count_q + LVL_W'(1);
    else if (!accept && pop) count_d = count_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q        <= '0;
      r_q        <= '0;
      b_q        <= '0;
      chsel_q    <= '0;
      bright_q   <= 8'hFF;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      g_q        <= g_d;
      r_q        <= r_d;
      b_q        <= b_d;
      chsel_q    <= chsel_d;
      bright_q   <= bright_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (accept) fifo_q[wr_ptr_q] <= new_entry;
  end

  ws2812_bit_engine #(
    .NUM_CH   (NUM_CH),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC),
    .TRST_CYC (TRST_CYC)
  ) u_engine (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_valid_i (!empty),
    .entry_i       (fifo_q[rd_ptr_q]),
    .bright_i      (bright_q),
    .entry_ready_o (pop),
    .led_o         (led),
    .active_o      (eng_active)
  );

  always_comb begin
    status                         = '0;
    status[STAT_BUSY]              = busy;
    status[STAT_EMPTY]             = empty;
    status[STAT_FULL]              = full;
    status[STAT_OVF]               = overflow_q;
    status[STAT_LEVEL_LSB +: 4]    = 4'(count_q);
    case (address)
      ADDR_CMD:    data_out = status;
      ADDR_G:      data_out = g_q;
      ADDR_R:      data_out = r_q;
      ADDR_B:      data_out = b_q;
      ADDR_CHSEL:  data_out = 8'(chsel_q);
      ADDR_BRIGHT: data_out = bright_q;
      default:     data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_multi_driver.sv
// Testbench for ws2812b_multi_driver with short sim timing.
// Stimulus queues expected pixels; a monitor decodes the strip lines and compares.
module tb_ws2812b_multi_driver;

  localparam int unsigned NUM_CH = 4;
  localparam int T0H = 2, T1H = 5, TBIT = 8, TRST = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        address = '0;
  logic              data_write = 1'b0;
  logic [7:0]        data_in = '0;
  logic [7:0]        data_out;
  logic [NUM_CH-1:0] led;
  logic              busy;

  always #5 clk = ~clk;

  ws2812b_multi_driver #(
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (4),
    .T0H_CYC    (T0H),
    .T1H_CYC    (T1H),
    .TBIT_CYC   (TBIT),
    .TRST_CYC   (TRST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out),
    .led        (led),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [23:0] grb;
    bit          contig;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a;
    #1 d = data_out;
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [23:0] grb, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ch = ch; e.grb = grb; e.contig = (i != 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic set_pix(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                         input logic [7:0] ch);
    wr(4'h1, g); wr(4'h2, r); wr(4'h3, b); wr(4'h4, ch);
  endtask

  task automatic wait_idle(input string nm, output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  // Monitor: decode pulses into bits, 24 bits into a pixel, compare with the queue head.
  int                cyc = 0, last_rise = 0, first_gap = 0, hi_cnt = 0, nbits = 0;
  logic [NUM_CH-1:0] prev_led = '0;
  logic [1:0]        cur_ch = '0, pix_ch = '0;
  logic [23:0]       sh = '0;
  logic              pix_ok = 1'b1;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        nbits = 0; hi_cnt = 0; prev_led = '0; pix_ok = 1'b1;
      end else begin
        if ($countones(led) > 1) pix_ok = 1'b0;
        if (prev_led == '0 && led != '0) begin
          for (int unsigned i = 0; i < NUM_CH; i++) if (led[i]) cur_ch = 2'(i);
          if (nbits == 0) begin
            first_gap = cyc - last_rise;
            pix_ch    = cur_ch;
          end else begin
            if (cyc - last_rise != TBIT) pix_ok = 1'b0;
            if (cur_ch != pix_ch) pix_ok = 1'b0;
          end
          last_rise = cyc;
          hi_cnt    = 1;
        end else if (led != '0) begin
          if (led != prev_led) pix_ok = 1'b0;
          hi_cnt++;
        end else if (prev_led != '0) begin
          if (hi_cnt != T1H && hi_cnt != T0H) pix_ok = 1'b0;
          sh = {sh[22:0], (hi_cnt == T1H)};
          nbits++;
          if (nbits == 24) begin
            if (sb_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_pixel: got ch=%0d grb=0x%06h, required no pixel", pix_ch, sh);
            end else begin
              e = sb_q.pop_front();
              chk("pix_ch", 32'(pix_ch), 32'(e.ch));
              chk("pix_grb", 32'(sh), 32'(e.grb));
              chk("pix_timing", 32'(pix_ok), 32'd1);
              if (e.contig) chk("pix_gap", 32'(first_gap), 32'(TBIT));
            end
            nbits  = 0;
            pix_ok = 1'b1;
          end
        end
        prev_led = led;
      end
    end
  end

  // Brightness table: {bright, G, R, B, expected GRB on the wire}
  typedef struct { logic [7:0] br, g, r, b; logic [23:0] exp; } bright_t;
  bright_t btab[3] = '{
    '{8'h7F, 8'hFF, 8'hFF, 8'hFF, 24'h7F7F7F},
    '{8'h3F, 8'hC8, 8'h10, 8'h01, 24'h320400},
    '{8'h00, 8'hFF, 8'hFF, 8'hFF, 24'h000000}
  };

  initial begin : stim
    logic [7:0] d;
    int         n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    rd(4'h0, d); chk("rst_status", 32'(d), 32'h02);
    rd(4'h5, d); chk("rst_bright", 32'(d), 32'hFF);
    rd(4'h1, d); chk("rst_g", 32'(d), 32'h00);
    rd(4'h6, d); chk("unmapped_rd", 32'(d), 32'h00);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single latched pixel, MSB-first, latency and latch window
    set_pix(8'h80, 8'h00, 8'h00, 8'h00);
    push_exp(2'd0, 24'h800000, 1);
    wr(4'h0, 8'h80);
    @(negedge clk); chk("latency_e1", 32'(led), 32'h0);
    @(negedge clk); chk("latency_e2", 32'(led), 32'h1);
    chk("busy_active", 32'(busy), 32'h1);
    wait_idle("idle_t1", n);
    chk("latch_window", 32'(n), 32'(24 * TBIT + TRST));
    rd(4'h0, d); chk("status_t1", 32'(d), 32'h02);

    // Four back-to-back pixels from one entry, no latch
    set_pix(8'hA5, 8'h3C, 8'h0F, 8'h00);
    push_exp(2'd0, 24'hA53C0F, 4);
    wr(4'h0, 8'h03);
    wait_idle("idle_t2", n);

    // Overflow: engine busy with A, then six pushes into a 4-deep FIFO
    set_pix(8'h10, 8'h02, 8'h03, 8'h01);
    push_exp(2'd1, 24'h100203, 1);
    wr(4'h0, 8'h00);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wr(4'h1, 8'(8'h11 + i));
      wr(4'h0, 8'h00);
      if (i < 4) push_exp(2'd1, {8'(8'h11 + i), 16'h0203}, 1);
    end
    rd(4'h0, d); chk("status_ovf", 32'(d), 32'h4D);
    wr(4'h7, 8'hA5);
    rd(4'h0, d); chk("status_clr", 32'(d), 32'h45);
    wait_idle("idle_t3", n);

    // Brightness scaling on channel 2
    for (int i = 0; i < 3; i++) begin
      wr(4'h5, btab[i].br);
      set_pix(btab[i].g, btab[i].r, btab[i].b, 8'h02);
      push_exp(2'd2, btab[i].exp, 1);
      wr(4'h0, 8'h80);
      wait_idle("idle_t4", n);
    end
    wr(4'h5, 8'hFF);

    // Channel switch between entries
    set_pix(8'hAA, 8'h55, 8'hF0, 8'h02);
    push_exp(2'd2, 24'hAA55F0, 1);
    wr(4'h0, 8'h00);
    set_pix(8'h0F, 8'hF0, 8'h81, 8'h01);
    push_exp(2'd1, 24'h0FF081, 1);
    wr(4'h0, 8'h80);
    wait_idle("idle_t5", n);
    rd(4'h0, d); chk("status_t5", 32'(d), 32'h02);

    // Reset mid-frame: queued and in-flight work is discarded
    wr(4'h5, 8'h40);
    set_pix(8'hFF, 8'h00, 8'h00, 8'h03);
    wr(4'h0, 8'h05);
    wr(4'h0, 8'h80);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_led", 32'(led), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    #1 chk("rst_mid_status", 32'(data_out), 32'h02);
    @(negedge clk);
    rst_n = 1'b1;
    rd(4'h5, d); chk("rst_mid_bright", 32'(d), 32'hFF);
    repeat (300) @(negedge clk);
    chk("rst_no_resume", 32'(busy), 32'h0);
    set_pix(8'h5A, 8'hA5, 8'h3C, 8'h03);
    rd(4'h4, d); chk("chsel_rd", 32'(d), 32'h03);
    push_exp(2'd3, 24'h5AA53C, 1);
    wr(4'h0, 8'h80);
    wait_idle("idle_t6", n);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
